// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer.
//   - next-PC select encodings (SEL_*)
//   - sequencer FSM state type
//   - branch offset helper: word offset to byte offset
package pc_pkg;

  localparam logic [2:0] SEL_SEQ = 3'd0;
  localparam logic [2:0] SEL_J   = 3'd1;
  localparam logic [2:0] SEL_BR  = 3'd2;
  localparam logic [2:0] SEL_JR  = 3'd3;
  localparam logic [2:0] SEL_JAL = 3'd4;
  localparam logic [2:0] SEL_RET = 3'd5;

  typedef enum logic [1:0] {
    StBoot = 2'd0,
    StRun  = 2'd1,
    StHalt = 2'd2
  } pc_state_e;

  // The result is signed.
  // A size cast at the use site sign-extends it to XLEN, or truncates it to XLEN.
  function automatic logic signed [33:0] br_offset(input logic [31:0] imm);
    return signed'({imm, 2'b00});
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/fetch bundle of the PC sequencer.
//   master: control unit and fetch side; it drives sel, operands, halt/resume/exc and pc_ready.
//   slave : the sequencer; it drives pc, pc_valid, misaligned and ras_count.
interface pc_sequencer_if #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned RAS_DEPTH = 4
);
  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

  logic [2:0]      sel;
  logic [31:0]     immediate;
  logic [25:0]     jump_addr;
  logic [XLEN-1:0] reg_rs;
  logic            pc_ready;
  logic            halt;
  logic            resume;
  logic            exc;
  logic [XLEN-1:0] pc;
  logic            pc_valid;
  logic            misaligned;
  logic [CW-1:0]   ras_count;

  modport master (
    output sel, immediate, jump_addr, reg_rs, pc_ready, halt, resume, exc,
    input  pc, pc_valid, misaligned, ras_count
  );

  modport slave (
    input  sel, immediate, jump_addr, reg_rs, pc_ready, halt, resume, exc,
    output pc, pc_valid, misaligned, ras_count
  );
endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack.
//   push/push_data : store a return address; when the stack is full, the oldest entry is overwritten
//   pop            : discard the top entry; the caller pops only when count != 0
//   top            : most recently pushed live entry
//   count          : live entries, saturating at RAS_DEPTH
module pc_ras #(
  parameter int unsigned RAS_DEPTH = 4,
  parameter int unsigned XLEN      = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push,
  input  logic                           pop,
  input  logic [XLEN-1:0]                push_data,
  output logic [XLEN-1:0]                top,
  output logic [$clog2(RAS_DEPTH+1)-1:0] count
);
  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);
  localparam logic [CW-1:0] Full  = CW'(RAS_DEPTH);
  localparam logic [PW-1:0] PtrOne = PW'(1);
  localparam logic [CW-1:0] CntOne = CW'(1);

  logic [XLEN-1:0] mem_q [RAS_DEPTH];
  logic [PW-1:0]   ptr_q, ptr_d;   // next free slot; wraps naturally (power-of-two depth)
  logic [CW-1:0]   count_q, count_d;

  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    if (push) begin
      ptr_d   = ptr_q + PtrOne;
      count_d = (count_q == Full) ? count_q : count_q + CntOne;
    end else if (pop && count_q != '0) begin
      ptr_d   = ptr_q - PtrOne;
      count_d = count_q - CntOne;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  // The storage array has no reset; contents beyond count are don't-care.
  always_ff @(posedge clk) begin
    if (push) mem_q[ptr_q] <= push_data;
  end

  assign top   = mem_q[ptr_q - PtrOne];
  assign count = count_q;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with a fetch handshake, halt/resume control and a return-address stack.
//   clk, rst_n : clock; asynchronous active-low reset
//   bus        : pc_sequencer_if slave
//                inputs  sel, immediate, jump_addr, reg_rs, pc_ready, halt, resume, exc
//                outputs pc, pc_valid, misaligned, ras_count
// Edge priority: exc > misaligned target > halt > fire (fire = RUN && pc_ready).
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,  // 32..64 supported
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] EXC_VECTOR   = XLEN'(32'h0000_0180),
  parameter int unsigned     RAS_DEPTH    = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  pc_sequencer_if.slave bus
);
  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;
  logic            mis_q, mis_d;

  logic [XLEN-1:0] p4, j_target, br_target, next_pc, ras_top;
  logic [CW-1:0]   ras_count;
  logic            indirect, want_push, want_pop, push, pop, fire;

  assign p4        = pc_q + XLEN'(4);
  assign j_target  = {p4[XLEN-1:28], bus.jump_addr, 2'b00};
  assign br_target = p4 + XLEN'(br_offset(bus.immediate));
  assign fire      = (state_q == StRun) && bus.pc_ready;

  // Target selection and RAS intent. Any effect occurs only when the FSM commits a fire.
  always_comb begin
    next_pc   = p4;
    indirect  = 1'b0;
    want_push = 1'b0;
    want_pop  = 1'b0;
    case (bus.sel)
      SEL_J:   next_pc = j_target;
      SEL_BR:  next_pc = br_target;
      SEL_JR: begin
        next_pc  = bus.reg_rs;
        indirect = 1'b1;
      end
      SEL_JAL: begin
        next_pc   = j_target;
        want_push = 1'b1;
      end
      SEL_RET: begin
        // An empty stack falls back to reg_rs.
        next_pc  = (ras_count != '0) ? ras_top : bus.reg_rs;
        indirect = 1'b1;
        want_pop = (ras_count != '0);
      end
      default: next_pc = p4;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    mis_d   = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      StBoot: state_d = StRun;
      StRun: begin
        if (bus.exc) begin
          pc_d = EXC_VECTOR;
        end else if (fire && indirect && next_pc[1:0] != 2'b00) begin
          // A rejected RET target still consumes its stack entry.
          pc_d  = EXC_VECTOR;
          mis_d = 1'b1;
          pop   = want_pop;
        end else if (bus.halt) begin
          state_d = StHalt;
        end else if (fire) begin
          pc_d = next_pc;
          push = want_push;
          pop  = want_pop;
        end
      end
      StHalt: begin
        if (bus.exc) begin
          pc_d    = EXC_VECTOR;
          state_d = StRun;
        end else if (bus.resume) begin
          state_d = StRun;
        end
      end
      default: state_d = StBoot;
    endcase
    valid_d = (state_d == StRun);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StBoot;
      pc_q    <= RESET_VECTOR;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
    end
  end

  pc_ras #(
    .RAS_DEPTH (RAS_DEPTH),
    .XLEN      (XLEN)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .push_data (p4),
    .top       (ras_top),
    .count     (ras_count)
  );

  assign bus.pc         = pc_q;
  assign bus.pc_valid   = valid_q;
  assign bus.misaligned = mis_q;
  assign bus.ras_count  = ras_count;

endmodule
